// File: rtl/esm_dwell_sequencer.sv
// ESM dwell sequencer: walks an instruction/entry program, retunes the AD9361 through
// fast-lock profiles, waits for PLL lock, then holds each dwell for its programmed duration.
module esm_dwell_sequencer #(
  parameter int NUM_ENTRIES                = 16,
  parameter int NUM_INSTRUCTIONS           = 32,
  parameter int METADATA_WIDTH             = 160,
  parameter int DURATION_WIDTH             = 32,
  parameter int STATUS_WIDTH               = 8,
  parameter int PLL_PRE_LOCK_DELAY_CYCLES  = 8,
  parameter int PLL_POST_LOCK_DELAY_CYCLES = 10,
  parameter int LOCK_TIMEOUT_CYCLES        = 1024
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      Entry_wr_en,
  input  logic [7:0]                Entry_wr_index,
  input  logic [METADATA_WIDTH-1:0] Entry_wr_metadata,
  input  logic [DURATION_WIDTH-1:0] Entry_wr_duration,
  input  logic [3:0]                Entry_wr_profile,
  input  logic                      Instr_wr_en,
  input  logic [7:0]                Instr_wr_index,
  input  logic [31:0]               Instr_wr_data,
  input  logic                      Program_start,
  input  logic                      Program_enable,
  input  logic                      Delayed_start_enable,
  input  logic [63:0]               Delayed_start_time,
  input  logic [31:0]               Global_counter_init,
  output logic [3:0]                Ad9361_control,
  input  logic [STATUS_WIDTH-1:0]   Ad9361_status,
  output logic [63:0]               Timestamp,
  output logic                      Dwell_active,
  output logic [METADATA_WIDTH-1:0] Dwell_data,
  output logic                      Dwell_done,
  output logic                      Program_running,
  output logic                      Program_finished,
  output logic                      Lock_timeout
);

  localparam int EI_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int II_W = (NUM_INSTRUCTIONS > 1) ? $clog2(NUM_INSTRUCTIONS) : 1;
  localparam logic [31:0] PRE_LOAD  = 32'(PLL_PRE_LOCK_DELAY_CYCLES - 1);
  localparam logic [31:0] POST_LOAD = 32'(PLL_POST_LOCK_DELAY_CYCLES - 1);
  localparam logic [31:0] TO_LOAD   = 32'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [DURATION_WIDTH-1:0] DUR_ONE = DURATION_WIDTH'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_START, S_FETCH, S_CHECK, S_PRE_LOCK,
    S_WAIT_LOCK, S_POST_LOCK, S_DWELL, S_NEXT
  } state_t;

  state_t state, state_nxt;

  logic [METADATA_WIDTH-1:0] ent_meta [NUM_ENTRIES];
  logic [DURATION_WIDTH-1:0] ent_dur  [NUM_ENTRIES];
  logic [3:0]                ent_prof [NUM_ENTRIES];
  logic [7:0]                ins_next [NUM_INSTRUCTIONS];
  logic [EI_W-1:0]           ins_ent  [NUM_INSTRUCTIONS];
  logic [7:0]                ins_rep  [NUM_INSTRUCTIONS];
  logic                      ins_gcc  [NUM_INSTRUCTIONS];
  logic                      ins_gcd  [NUM_INSTRUCTIONS];
  logic [NUM_INSTRUCTIONS-1:0] ins_vld;

  logic                      vld_p1, gcc_p1, gcd_p1;
  logic [7:0]                rep_p1, next_p1;
  logic [METADATA_WIDTH-1:0] meta_p1;
  logic [DURATION_WIDTH-1:0] dur_p1;
  logic [3:0]                prof_p1;

  logic [7:0]                ptr, rep;
  logic [31:0]               gc, gc_next, phase_cnt;
  logic [DURATION_WIDTH-1:0] dwell_cnt, dur_load;
  logic                      first_dwell, ds_en;
  logic [63:0]               ds_time;

  logic [EI_W-1:0] ewa;
  logic [II_W-1:0] iwa, ptr_lo;
  logic            instr_wr_ok, start_ok, prog_end, skip_retune, phase_zero;
  logic            pll_locked, dwell_last, rep_more, rep_continue;
  logic            unused_bits;

  assign ewa         = Entry_wr_index[EI_W-1:0];
  assign iwa         = Instr_wr_index[II_W-1:0];
  assign ptr_lo      = ptr[II_W-1:0];
  assign instr_wr_ok = {24'd0, Instr_wr_index} < 32'(NUM_INSTRUCTIONS);
  assign unused_bits = ^{Entry_wr_index, Instr_wr_data[7:3], Instr_wr_data[23:16]};

  assign start_ok     = !ds_en || (Timestamp >= ds_time);
  assign prog_end     = !vld_p1 || ({24'd0, ptr} >= 32'(NUM_INSTRUCTIONS)) || (gcc_p1 && gc == '0);
  assign skip_retune  = (prof_p1 == Ad9361_control) && !first_dwell;
  assign phase_zero   = (phase_cnt == '0);
  assign pll_locked   = &Ad9361_status;
  assign dwell_last   = (dwell_cnt == DUR_ONE);
  assign dur_load     = (dur_p1 == '0) ? DUR_ONE : dur_p1;
  assign gc_next      = (gcd_p1 && gc != '0) ? gc - 32'd1 : gc;
  assign rep_more     = (rep != '0);
  assign rep_continue = !gcc_p1 || (gc_next != '0);

  // Program RAMs and fetch stage (p1): entry address is chained off the instruction read
  always_ff @(posedge Clk) begin
    if (Entry_wr_en) begin
      ent_meta[ewa] <= Entry_wr_metadata;
      ent_dur[ewa]  <= Entry_wr_duration;
      ent_prof[ewa] <= Entry_wr_profile;
    end
    if (Instr_wr_en && instr_wr_ok) begin
      ins_next[iwa] <= Instr_wr_data[31:24];
      ins_ent[iwa]  <= Instr_wr_data[16 +: EI_W];
      ins_rep[iwa]  <= Instr_wr_data[15:8];
      ins_gcc[iwa]  <= Instr_wr_data[1];
      ins_gcd[iwa]  <= Instr_wr_data[2];
    end
    if (state == S_FETCH) begin
      gcc_p1  <= ins_gcc[ptr_lo];
      gcd_p1  <= ins_gcd[ptr_lo];
      rep_p1  <= ins_rep[ptr_lo];
      next_p1 <= ins_next[ptr_lo];
      meta_p1 <= ent_meta[ins_ent[ptr_lo]];
      dur_p1  <= ent_dur[ins_ent[ptr_lo]];
      prof_p1 <= ent_prof[ins_ent[ptr_lo]];
    end
  end

  // Instruction valid bits are reset so an unwritten RAM reads as an empty program
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ins_vld <= '0;
      vld_p1  <= 1'b0;
    end else begin
      if (Instr_wr_en && instr_wr_ok) ins_vld[iwa] <= Instr_wr_data[0];
      if (state == S_FETCH) vld_p1 <= ins_vld[ptr_lo];
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (Program_start)       state_nxt = Program_enable ? S_WAIT_START : S_IDLE;
    else if (!Program_enable) state_nxt = S_IDLE;
    else begin
      case (state)
        S_IDLE:       state_nxt = S_IDLE;
        S_WAIT_START: if (start_ok) state_nxt = S_FETCH;
        S_FETCH:      state_nxt = S_CHECK;
        S_CHECK:      state_nxt = prog_end ? S_IDLE : (skip_retune ? S_DWELL : S_PRE_LOCK);
        S_PRE_LOCK:   if (phase_zero) state_nxt = S_WAIT_LOCK;
        S_WAIT_LOCK:  if (pll_locked || phase_zero) state_nxt = S_POST_LOCK;
        S_POST_LOCK:  if (phase_zero) state_nxt = S_DWELL;
        S_DWELL:      if (dwell_last) state_nxt = !rep_more ? S_NEXT : (rep_continue ? S_DWELL : S_IDLE);
        S_NEXT:       state_nxt = S_FETCH;
        default:      state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    Dwell_active     = (state == S_DWELL);
    Dwell_done       = (state == S_DWELL) && dwell_last;
    Program_running  = (state != S_IDLE);
    Program_finished = 1'b0;
    if (!Program_start && Program_enable) begin
      if (state == S_CHECK && prog_end) Program_finished = 1'b1;
      if (state == S_DWELL && dwell_last && rep_more && !rep_continue) Program_finished = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Timestamp      <= '0;
      ptr            <= '0;
      rep            <= '0;
      gc             <= '0;
      phase_cnt      <= '0;
      dwell_cnt      <= '0;
      first_dwell    <= 1'b1;
      ds_en          <= 1'b0;
      ds_time        <= '0;
      Ad9361_control <= '0;
      Dwell_data     <= '0;
      Lock_timeout   <= 1'b0;
    end else begin
      Timestamp <= Timestamp + 64'd1;
      if (Program_start) begin
        gc           <= Global_counter_init;
        ptr          <= '0;
        first_dwell  <= 1'b1;
        Lock_timeout <= 1'b0;
        ds_en        <= Delayed_start_enable;
        ds_time      <= Delayed_start_time;
      end else begin
        case (state)
          S_CHECK: if (!prog_end) begin
            rep <= rep_p1;
            if (skip_retune) begin
              dwell_cnt  <= dur_load;
              Dwell_data <= meta_p1;
            end else begin
              Ad9361_control <= prof_p1;
              phase_cnt      <= PRE_LOAD;
            end
          end
          S_PRE_LOCK: phase_cnt <= phase_zero ? TO_LOAD : phase_cnt - 32'd1;
          S_WAIT_LOCK: begin
            if (pll_locked) phase_cnt <= POST_LOAD;
            else if (phase_zero) begin
              Lock_timeout <= 1'b1;
              phase_cnt    <= POST_LOAD;
            end else phase_cnt <= phase_cnt - 32'd1;
          end
          S_POST_LOCK: begin
            if (phase_zero) begin
              dwell_cnt  <= dur_load;
              Dwell_data <= meta_p1;
            end else phase_cnt <= phase_cnt - 32'd1;
          end
          S_DWELL: begin
            first_dwell <= 1'b0;
            if (dwell_last) begin
              gc <= gc_next;
              if (rep_more) begin
                rep       <= rep - 8'd1;
                dwell_cnt <= dur_load;
              end
            end else dwell_cnt <= dwell_cnt - DUR_ONE;
          end
          S_NEXT:  ptr <= next_p1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_esm_dwell_sequencer.sv
// Directed bench for esm_dwell_sequencer: a table of single-instruction programs plus
// hand-written multi-instruction, timing, timeout, abort and reset sequences.
module tb_esm_dwell_sequencer;

  logic         Clk = 1'b0;
  logic         Rst_n = 1'b0;
  logic         Entry_wr_en = 1'b0;
  logic [7:0]   Entry_wr_index = '0;
  logic [159:0] Entry_wr_metadata = '0;
  logic [31:0]  Entry_wr_duration = '0;
  logic [3:0]   Entry_wr_profile = '0;
  logic         Instr_wr_en = 1'b0;
  logic [7:0]   Instr_wr_index = '0;
  logic [31:0]  Instr_wr_data = '0;
  logic         Program_start = 1'b0;
  logic         Program_enable = 1'b1;
  logic         Delayed_start_enable = 1'b0;
  logic [63:0]  Delayed_start_time = '0;
  logic [31:0]  Global_counter_init = '0;
  logic [3:0]   Ad9361_control;
  logic [7:0]   Ad9361_status = 8'hFF;
  logic [63:0]  Timestamp;
  logic         Dwell_active;
  logic [159:0] Dwell_data;
  logic         Dwell_done;
  logic         Program_running;
  logic         Program_finished;
  logic         Lock_timeout;

  always #5 Clk = ~Clk;

  esm_dwell_sequencer dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Entry_wr_en(Entry_wr_en), .Entry_wr_index(Entry_wr_index),
    .Entry_wr_metadata(Entry_wr_metadata), .Entry_wr_duration(Entry_wr_duration),
    .Entry_wr_profile(Entry_wr_profile),
    .Instr_wr_en(Instr_wr_en), .Instr_wr_index(Instr_wr_index), .Instr_wr_data(Instr_wr_data),
    .Program_start(Program_start), .Program_enable(Program_enable),
    .Delayed_start_enable(Delayed_start_enable), .Delayed_start_time(Delayed_start_time),
    .Global_counter_init(Global_counter_init),
    .Ad9361_control(Ad9361_control), .Ad9361_status(Ad9361_status),
    .Timestamp(Timestamp), .Dwell_active(Dwell_active), .Dwell_data(Dwell_data),
    .Dwell_done(Dwell_done), .Program_running(Program_running),
    .Program_finished(Program_finished), .Lock_timeout(Lock_timeout)
  );

  int errors = 0;
  int checks = 0;

  // Observed activity, sampled on the falling edge
  int          done_cnt = 0, fin_cnt = 0, ctrl_chg = 0, wn = 0, gn = 0, cur_w = 0, idle_run = 0;
  int          widths [1024];
  int          gaps [1024];
  logic        prev_act = 1'b0;
  logic [3:0]  prev_ctrl = 4'd0;
  logic [63:0] chg_ts = '0;

  always @(negedge Clk) begin
    if (!Rst_n) begin
      cur_w     <= 0;
      idle_run  <= 0;
      prev_act  <= 1'b0;
      prev_ctrl <= 4'd0;
    end else begin
      prev_act  <= Dwell_active;
      prev_ctrl <= Ad9361_control;
      if (Dwell_done) done_cnt <= done_cnt + 1;
      if (Program_finished) fin_cnt <= fin_cnt + 1;
      if (Ad9361_control != prev_ctrl) begin
        ctrl_chg <= ctrl_chg + 1;
        chg_ts   <= Timestamp;
      end
      if (Dwell_active) begin
        idle_run <= 0;
        if (!prev_act) begin
          gaps[gn % 1024] <= idle_run;
          gn <= gn + 1;
        end
        if (Dwell_done) begin
          widths[wn % 1024] <= cur_w + 1;
          wn    <= wn + 1;
          cur_w <= 0;
        end else cur_w <= cur_w + 1;
      end else begin
        cur_w    <= 0;
        idle_run <= idle_run + 1;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_meta(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  function automatic logic [159:0] meta_of(input int i);
    return {32'hC0DE_0000 + 32'(i), 96'h0123_4567_89AB_CDEF_0F1E_2D3C, 32'(i * 17 + 5)};
  endfunction

  function automatic logic [31:0] ins(input bit v, input bit gcc, input bit gcd,
                                      input int rep, input int ent, input int nxt);
    return {8'(nxt), 8'(ent), 8'(rep), 5'd0, gcd, gcc, v};
  endfunction

  task automatic wr_entry(input int idx, input int dur, input int prof);
    Entry_wr_en = 1'b1;
    Entry_wr_index = 8'(idx);
    Entry_wr_metadata = meta_of(idx);
    Entry_wr_duration = 32'(dur);
    Entry_wr_profile = 4'(prof);
    tick();
    Entry_wr_en = 1'b0;
  endtask

  task automatic wr_instr(input int idx, input logic [31:0] w);
    Instr_wr_en = 1'b1;
    Instr_wr_index = 8'(idx);
    Instr_wr_data = w;
    tick();
    Instr_wr_en = 1'b0;
  endtask

  task automatic start(input logic [31:0] gci, input bit dse, input logic [63:0] dst);
    Global_counter_init = gci;
    Delayed_start_enable = dse;
    Delayed_start_time = dst;
    Program_start = 1'b1;
    tick();
    Program_start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (Program_running && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(Program_running), 64'd0);
  endtask

  task automatic wait_active(input string name, input int budget);
    int n = 0;
    while (!Dwell_active && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(Dwell_active), 64'd1);
  endtask

  typedef struct {
    int dur; int rep; int prof; bit gcc; bit gcd; int gci; int exp_done; int exp_w;
  } vec_t;

  vec_t vt [8];
  int   exp_a [5];
  int   d0, f0, w0, g0, c0;
  bit   wok;
  logic [63:0] t0;

  initial begin
    vt[0] = '{10, 0,  3, 1'b0, 1'b0, 0, 1, 10};
    vt[1] = '{0,  0,  7, 1'b0, 1'b0, 0, 1, 1};
    vt[2] = '{1,  3,  1, 1'b0, 1'b0, 0, 4, 1};
    vt[3] = '{4,  5,  9, 1'b1, 1'b1, 3, 3, 4};
    vt[4] = '{5,  2,  2, 1'b1, 1'b1, 0, 0, 5};
    vt[5] = '{2,  2,  4, 1'b0, 1'b1, 1, 3, 2};
    vt[6] = '{2,  1, 12, 1'b1, 1'b0, 5, 2, 2};
    vt[7] = '{3,  0,  6, 1'b1, 1'b0, 1, 1, 3};
    exp_a = '{100, 1, 1, 1, 5};

    // Reset state
    tick(2);
    check("rst_timestamp", Timestamp, 64'd0);
    check("rst_active", 64'(Dwell_active), 64'd0);
    check("rst_running", 64'(Program_running), 64'd0);
    check("rst_control", 64'(Ad9361_control), 64'd0);
    check("rst_timeout", 64'(Lock_timeout), 64'd0);
    check_meta("rst_data", Dwell_data, 160'd0);
    Rst_n = 1'b1;
    tick();
    check("ts_after_rst", Timestamp, 64'd1);

    // Table: single-instruction programs
    for (int i = 0; i < 8; i++) begin
      wr_entry(i, vt[i].dur, vt[i].prof);
      wr_instr(0, ins(1'b1, vt[i].gcc, vt[i].gcd, vt[i].rep, i, 1));
      wr_instr(1, ins(1'b0, 1'b0, 1'b0, 0, 0, 0));
      d0 = done_cnt; f0 = fin_cnt; w0 = wn;
      start(32'(vt[i].gci), 1'b0, 64'd0);
      wait_idle($sformatf("row%0d_idle", i), 5000);
      check($sformatf("row%0d_done", i), 64'(done_cnt - d0), 64'(vt[i].exp_done));
      check($sformatf("row%0d_finished", i), 64'(fin_cnt - f0), 64'd1);
      wok = 1'b1;
      for (int k = w0; k < wn; k++) if (widths[k % 1024] != vt[i].exp_w) wok = 1'b0;
      check($sformatf("row%0d_widths", i), 64'(wok), 64'd1);
      if (vt[i].exp_done > 0) begin
        check($sformatf("row%0d_control", i), 64'(Ad9361_control), 64'(vt[i].prof));
        check_meta($sformatf("row%0d_data", i), Dwell_data, meta_of(i));
      end
    end

    // Three instructions, durations 100/0/5, repeats 0/2/0, distinct profiles
    wr_entry(8, 100, 1);
    wr_entry(9, 0, 2);
    wr_entry(10, 5, 3);
    wr_instr(0, ins(1'b1, 1'b0, 1'b0, 0, 8, 1));
    wr_instr(1, ins(1'b1, 1'b0, 1'b0, 2, 9, 2));
    wr_instr(2, ins(1'b1, 1'b0, 1'b0, 0, 10, 3));
    wr_instr(3, ins(1'b0, 1'b0, 1'b0, 0, 0, 0));
    d0 = done_cnt; f0 = fin_cnt; w0 = wn; g0 = gn;
    start(32'd0, 1'b0, 64'd0);
    wait_idle("seq3_idle", 5000);
    check("seq3_done", 64'(done_cnt - d0), 64'd5);
    check("seq3_finished", 64'(fin_cnt - f0), 64'd1);
    for (int k = 0; k < 5; k++) check($sformatf("seq3_width%0d", k), 64'(widths[(w0 + k) % 1024]), 64'(exp_a[k]));
    check("seq3_gap1", 64'(gaps[(g0 + 1) % 1024]), 64'd22);
    check("seq3_gap2", 64'(gaps[(g0 + 2) % 1024]), 64'd22);
    check("seq3_control", 64'(Ad9361_control), 64'd3);
    check_meta("seq3_data", Dwell_data, meta_of(10));

    // Looping program bounded by the global dwell counter
    wr_entry(11, 3, 4);
    wr_entry(12, 3, 5);
    wr_instr(0, ins(1'b1, 1'b1, 1'b1, 0, 11, 1));
    wr_instr(1, ins(1'b1, 1'b1, 1'b1, 0, 12, 0));
    d0 = done_cnt; f0 = fin_cnt;
    start(32'd7, 1'b0, 64'd0);
    wait_idle("loop_idle", 5000);
    check("loop_done", 64'(done_cnt - d0), 64'd7);
    check("loop_finished", 64'(fin_cnt - f0), 64'd1);

    // Same profile on consecutive instructions: one retune only
    wr_entry(13, 4, 8);
    wr_entry(14, 4, 8);
    wr_instr(0, ins(1'b1, 1'b0, 1'b0, 0, 13, 1));
    wr_instr(1, ins(1'b1, 1'b0, 1'b0, 0, 14, 2));
    wr_instr(2, ins(1'b0, 1'b0, 1'b0, 0, 0, 0));
    d0 = done_cnt; g0 = gn; c0 = ctrl_chg;
    start(32'd0, 1'b0, 64'd0);
    wait_idle("same_idle", 5000);
    check("same_done", 64'(done_cnt - d0), 64'd2);
    check("same_ctrl_changes", 64'(ctrl_chg - c0), 64'd1);
    check("same_gap", 64'(gaps[(g0 + 1) % 1024]), 64'd3);
    check_meta("same_data", Dwell_data, meta_of(14));

    // Delayed start on the timestamp
    wr_entry(15, 2, 10);
    wr_instr(0, ins(1'b1, 1'b0, 1'b0, 0, 15, 1));
    wr_instr(1, ins(1'b0, 1'b0, 1'b0, 0, 0, 0));
    t0 = Timestamp; c0 = ctrl_chg; d0 = done_cnt;
    start(32'd0, 1'b1, t0 + 64'd5000);
    wait_idle("delay_idle", 6000);
    check("delay_ctrl_changes", 64'(ctrl_chg - c0), 64'd1);
    check("delay_not_early", 64'(chg_ts >= t0 + 64'd5000), 64'd1);
    check("delay_not_late", 64'(chg_ts <= t0 + 64'd5010), 64'd1);
    check("delay_done", 64'(done_cnt - d0), 64'd1);

    // Lock never reported: timeout, dwell still runs
    Ad9361_status = 8'h00;
    wr_entry(0, 6, 11);
    wr_instr(0, ins(1'b1, 1'b0, 1'b0, 0, 0, 1));
    wr_instr(1, ins(1'b0, 1'b0, 1'b0, 0, 0, 0));
    d0 = done_cnt;
    start(32'd0, 1'b0, 64'd0);
    tick(1033);
    check("timeout_not_yet", 64'(Lock_timeout), 64'd0);
    tick(3);
    check("timeout_set", 64'(Lock_timeout), 64'd1);
    wait_idle("timeout_idle", 200);
    check("timeout_done", 64'(done_cnt - d0), 64'd1);
    check("timeout_sticky", 64'(Lock_timeout), 64'd1);
    Ad9361_status = 8'hFF;

    // Program_start mid-dwell with a new program
    wr_entry(1, 1000, 13);
    wr_entry(3, 7, 14);
    wr_instr(0, ins(1'b1, 1'b0, 1'b0, 0, 1, 1));
    start(32'd0, 1'b0, 64'd0);
    check("abort_timeout_cleared", 64'(Lock_timeout), 64'd0);
    wait_active("abort_first_active", 200);
    tick(50);
    wr_instr(0, ins(1'b1, 1'b0, 1'b0, 0, 3, 1));
    d0 = done_cnt;
    start(32'd0, 1'b0, 64'd0);
    check("abort_inactive", 64'(Dwell_active), 64'd0);
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    wait_idle("abort_idle", 2000);
    check("abort_new_done", 64'(done_cnt - d0), 64'd1);
    check("abort_new_width", 64'(widths[(wn - 1) % 1024]), 64'd7);
    check("abort_new_control", 64'(Ad9361_control), 64'd14);
    check_meta("abort_new_data", Dwell_data, meta_of(3));

    // Asynchronous reset in the middle of a dwell
    wr_entry(4, 500, 15);
    wr_instr(0, ins(1'b1, 1'b0, 1'b0, 0, 4, 1));
    start(32'd0, 1'b0, 64'd0);
    wait_active("rst_mid_active", 200);
    tick(10);
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("rstmid_active", 64'(Dwell_active), 64'd0);
    check("rstmid_done", 64'(Dwell_done), 64'd0);
    check("rstmid_running", 64'(Program_running), 64'd0);
    check("rstmid_control", 64'(Ad9361_control), 64'd0);
    check("rstmid_timestamp", Timestamp, 64'd0);
    check_meta("rstmid_data", Dwell_data, 160'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    check("rstmid_ts_restart", Timestamp, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
